// File: rtl/csr_port_arbiter.sv
// csr_port_arbiter: round-robin arbiter of loader/multiplier bursts onto value, column and row-pointer RAM ports
module csr_port_arbiter #(
  parameter int RD_LAT = 1,
  parameter int MAX_BURST = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        l_req,
  input  logic        m_req,
  input  logic        l_last,
  input  logic        m_last,
  input  logic        l_we,
  input  logic        m_we,
  input  logic [1:0]  l_sel,
  input  logic [1:0]  m_sel,
  input  logic [13:0] l_addr,
  input  logic [13:0] m_addr,
  input  logic [31:0] l_wdata,
  input  logic [31:0] m_wdata,
  output logic        l_gnt,
  output logic        m_gnt,
  output logic        l_rvalid,
  output logic        m_rvalid,
  output logic [31:0] l_rdata,
  output logic [31:0] m_rdata,
  output logic [13:0] val_addr,
  output logic [13:0] col_addr,
  output logic [9:0]  row_addr,
  output logic        val_we,
  output logic        col_we,
  output logic        row_we,
  output logic [31:0] val_din,
  output logic [31:0] col_din,
  output logic [31:0] row_din,
  input  logic [31:0] val_dout,
  input  logic [31:0] col_dout,
  input  logic [31:0] row_dout,
  output logic        busy,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, GNT_L, GNT_M, TURN} state_t;
  state_t state, state_nx;
  logic rr_m, own_m, acc, legal, cmd, rel, a_we, a_last;
  logic [1:0] a_sel;
  logic [13:0] a_addr;
  logic [31:0] a_wdata, rd;
  logic [7:0] cnt;
  logic [RD_LAT:0] tv, tm;
  logic [RD_LAT:0][1:0] ts;
  always_comb begin
    own_m = state == GNT_M;
    acc = (state == GNT_L && l_req) || (own_m && m_req);
    a_last = own_m ? m_last : l_last;
    a_we = own_m ? m_we : l_we;
    a_sel = own_m ? m_sel : l_sel;
    a_addr = own_m ? m_addr : l_addr;
    a_wdata = own_m ? m_wdata : l_wdata;
    legal = a_sel != 2'd3 && !(a_sel == 2'd2 && |a_addr[13:10]);
    cmd = acc && legal;
    rel = acc && (a_last || cnt == 8'(MAX_BURST - 1));
    state_nx = state == IDLE ? (l_req && (rr_m || !m_req) ? GNT_L : m_req ? GNT_M : IDLE)
             : state == TURN ? IDLE : rel ? TURN : state;
    rd = ts[RD_LAT] == 2'd0 ? val_dout : ts[RD_LAT] == 2'd1 ? col_dout : row_dout;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      l_gnt <= 1'b0;
      m_gnt <= 1'b0;
      rr_m <= 1'b1;
      cnt <= '0;
      err <= 1'b0;
      tv <= '0;
      tm <= '0;
      ts <= '0;
      val_we <= 1'b0;
      col_we <= 1'b0;
      row_we <= 1'b0;
      val_addr <= '0;
      col_addr <= '0;
      row_addr <= '0;
      val_din <= '0;
      col_din <= '0;
      row_din <= '0;
    end else begin
      state <= state_nx;
      l_gnt <= state_nx == GNT_L;
      m_gnt <= state_nx == GNT_M;
      if (rel) rr_m <= own_m;
      cnt <= rel ? '0 : acc ? cnt + 8'd1 : cnt;
      err <= err | (acc && !legal);
      tv <= {tv[RD_LAT-1:0], cmd && !a_we};
      tm <= {tm[RD_LAT-1:0], own_m};
      ts <= {ts[RD_LAT-1:0], a_sel};
      val_we <= cmd && a_we && a_sel == 2'd0;
      col_we <= cmd && a_we && a_sel == 2'd1;
      row_we <= cmd && a_we && a_sel == 2'd2;
      if (cmd && a_sel == 2'd0) begin
        val_addr <= a_addr;
        val_din <= a_wdata;
      end
      if (cmd && a_sel == 2'd1) begin
        col_addr <= a_addr;
        col_din <= a_wdata;
      end
      if (cmd && a_sel == 2'd2) begin
        row_addr <= a_addr[9:0];
        row_din <= a_wdata;
      end
    end
  end
  assign l_rvalid = tv[RD_LAT] && !tm[RD_LAT];
  assign m_rvalid = tv[RD_LAT] && tm[RD_LAT];
  assign l_rdata = l_rvalid ? rd : '0;
  assign m_rdata = m_rvalid ? rd : '0;
  assign busy = state != IDLE || |tv;
endmodule

// File: tb/tb_csr_port_arbiter.sv
// tb_csr_port_arbiter: directed and randomized checks of csr_port_arbiter against a transaction-level model
module tb_csr_port_arbiter;
  localparam int RL = 1, MB = 4;
  logic clk = 0, reset = 1;
  logic l_req = 0, m_req = 0, l_last = 0, m_last = 0, l_we = 0, m_we = 0;
  logic [1:0] l_sel = 0, m_sel = 0;
  logic [13:0] l_addr = 0, m_addr = 0;
  logic [31:0] l_wdata = 0, m_wdata = 0;
  logic l_gnt, m_gnt, l_rvalid, m_rvalid, val_we, col_we, row_we, busy, err;
  logic [31:0] l_rdata, m_rdata, val_din, col_din, row_din;
  logic [31:0] val_dout = 0, col_dout = 0, row_dout = 0;
  logic [13:0] val_addr, col_addr;
  logic [9:0] row_addr;
  int checks = 0, fails = 0;
  logic [31:0] ram [3][16384];
  bit wr [3][16384];
  logic [31:0] mem [3][16384];
  bit mwr [3][16384];
  typedef struct {int due; bit m; logic [31:0] d;} ret_t;
  ret_t rq[$];
  int e = 0, st = 0, n = 0;
  bit last_m = 1, merr = 0;
  logic [2:0] xwe = 0;
  logic [13:0] xaddr [3];
  logic [31:0] xdin [3];

  csr_port_arbiter #(.RD_LAT(RL), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .l_req(l_req), .m_req(m_req), .l_last(l_last), .m_last(m_last),
    .l_we(l_we), .m_we(m_we), .l_sel(l_sel), .m_sel(m_sel),
    .l_addr(l_addr), .m_addr(m_addr), .l_wdata(l_wdata), .m_wdata(m_wdata),
    .l_gnt(l_gnt), .m_gnt(m_gnt), .l_rvalid(l_rvalid), .m_rvalid(m_rvalid),
    .l_rdata(l_rdata), .m_rdata(m_rdata),
    .val_addr(val_addr), .col_addr(col_addr), .row_addr(row_addr),
    .val_we(val_we), .col_we(col_we), .row_we(row_we),
    .val_din(val_din), .col_din(col_din), .row_din(row_din),
    .val_dout(val_dout), .col_dout(col_dout), .row_dout(row_dout),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(int s, int a);
    return (32'h9E37_79B9 * (a + 1)) ^ (s << 28);
  endfunction

  always @(posedge clk) begin
    if (val_we) begin ram[0][val_addr] <= val_din; wr[0][val_addr] <= 1'b1; end
    if (col_we) begin ram[1][col_addr] <= col_din; wr[1][col_addr] <= 1'b1; end
    if (row_we) begin ram[2][{4'd0, row_addr}] <= row_din; wr[2][{4'd0, row_addr}] <= 1'b1; end
    val_dout <= wr[0][val_addr] ? ram[0][val_addr] : pat(0, int'(val_addr));
    col_dout <= wr[1][col_addr] ? ram[1][col_addr] : pat(1, int'(col_addr));
    row_dout <= wr[2][{4'd0, row_addr}] ? ram[2][{4'd0, row_addr}] : pat(2, int'(row_addr));
  end

  task automatic model_access(input bit om, input logic lst, input logic w, input logic [1:0] s,
                              input logic [13:0] a, input logic [31:0] d);
    if (s == 2'd3 || (s == 2'd2 && a[13:10] != 4'd0)) merr = 1;
    else begin
      xaddr[s] = s == 2'd2 ? {4'd0, a[9:0]} : a;
      if (w) begin
        xwe[s] = 1'b1;
        xdin[s] = d;
        mem[s][a] = d;
        mwr[s][a] = 1;
      end else rq.push_back('{e + RL, om, mwr[s][a] ? mem[s][a] : pat(int'(s), int'(a))});
    end
    n++;
    if (lst || n == MB) begin
      st = 3;
      last_m = om;
      n = 0;
    end
  endtask

  always @(posedge clk) begin
    e++;
    xwe = '0;
    while (rq.size() > 0 && rq[0].due < e) void'(rq.pop_front());
    if (reset) begin
      st = 0; n = 0; last_m = 1; merr = 0;
      rq.delete();
      xaddr = '{default: 0};
      xdin = '{default: 0};
    end
    else if (st == 3) st = 0;
    else if (st == 0) st = (l_req && (last_m || !m_req)) ? 1 : m_req ? 2 : 0;
    else if (st == 1 && l_req) model_access(0, l_last, l_we, l_sel, l_addr, l_wdata);
    else if (st == 2 && m_req) model_access(1, m_last, m_we, m_sel, m_addr, m_wdata);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    {l_req, m_req, l_last, m_last, l_we, m_we} = '0;
    reset = 1;
    tick;
    reset = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    tick;
    tick;
    checks++;
    if ({l_gnt, m_gnt, val_we, col_we, row_we, l_rvalid, m_rvalid, busy, err} !== 9'd0) begin
      fails++;
      $display("FAIL reset_ctl: got %b want 000000000", {l_gnt, m_gnt, val_we, col_we, row_we, l_rvalid, m_rvalid, busy, err});
    end
    checks++;
    if ({val_addr, col_addr, row_addr, val_din, col_din, row_din, l_rdata, m_rdata} !== '0) begin
      fails++;
      $display("FAIL reset_data: got addr %h %h %h din %h %h %h rdata %h %h want all 0",
               val_addr, col_addr, row_addr, val_din, col_din, row_din, l_rdata, m_rdata);
    end
  endtask

  task automatic test_write_burst;
    logic [31:0] dv [3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    do_reset;
    l_req = 1; l_we = 1; l_sel = 0; l_addr = 5; l_wdata = dv[0];
    tick;
    checks++;
    if ({l_gnt, val_we} !== 2'b10) begin
      fails++;
      $display("FAIL burst_gnt: got gnt=%b we=%b want gnt=1 we=0", l_gnt, val_we);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({l_gnt, val_we, val_addr, val_din} !== {i < 2, 1'b1, 14'(5 + i), dv[i]}) begin
        fails++;
        $display("FAIL burst_write[%0d]: got gnt=%b we=%b addr=%0d din=%h want gnt=%b we=1 addr=%0d din=%h",
                 i, l_gnt, val_we, val_addr, val_din, i < 2, 5 + i, dv[i]);
      end
      if (i < 2) begin
        l_addr = 14'(6 + i);
        l_wdata = dv[i + 1];
        l_last = i == 1;
      end
    end
    l_req = 0;
    tick;
    checks++;
    if ({l_gnt, val_we, busy} !== 3'b000) begin
      fails++;
      $display("FAIL burst_idle: got gnt=%b we=%b busy=%b want 000", l_gnt, val_we, busy);
    end
  endtask

  task automatic test_contention;
    logic [1:0] pat_g [7] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
    do_reset;
    l_req = 1; m_req = 1; l_last = 1; m_last = 1; l_we = 1; m_we = 1;
    l_sel = 0; m_sel = 0; l_addr = 100; m_addr = 101; l_wdata = 1; m_wdata = 2;
    for (int i = 0; i < 7; i++) begin
      tick;
      checks++;
      if ({l_gnt, m_gnt} !== pat_g[i]) begin
        fails++;
        $display("FAIL contention[cycle %0d]: got l/m gnt=%b want %b", i + 1, {l_gnt, m_gnt}, pat_g[i]);
      end
    end
    l_req = 0; m_req = 0;
  endtask

  task automatic test_read;
    do_reset;
    m_req = 1; m_we = 1; m_sel = 1; m_addr = 14'h0010; m_wdata = 32'hDEADBEEF; m_last = 1;
    tick;
    tick;
    m_we = 0;
    tick;
    tick;
    checks++;
    if (m_gnt !== 1'b1) begin
      fails++;
      $display("FAIL read_gnt: got m_gnt=%b want 1", m_gnt);
    end
    tick;
    m_req = 0;
    checks++;
    if ({l_rvalid, m_rvalid} !== 2'b00) begin
      fails++;
      $display("FAIL read_early: got l/m rvalid=%b want 00", {l_rvalid, m_rvalid});
    end
    tick;
    checks++;
    if ({m_rvalid, m_rdata, l_rvalid, l_rdata} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'd0}) begin
      fails++;
      $display("FAIL read_return: got m_rvalid=%b m_rdata=%h l_rvalid=%b l_rdata=%h want 1 deadbeef 0 0",
               m_rvalid, m_rdata, l_rvalid, l_rdata);
    end
    tick;
    checks++;
    if ({l_rvalid, m_rvalid} !== 2'b00) begin
      fails++;
      $display("FAIL read_once: got l/m rvalid=%b want 00", {l_rvalid, m_rvalid});
    end
  endtask

  task automatic test_max_burst;
    logic [6:0] want = 7'b1111001;
    int pulses = 0;
    do_reset;
    l_req = 1; l_we = 1; l_sel = 0; l_last = 0; l_addr = 200;
    for (int i = 0; i < 7; i++) begin
      tick;
      if (i > 0 && val_we) pulses++;
      checks++;
      if (l_gnt !== want[6 - i]) begin
        fails++;
        $display("FAIL max_burst_gnt[cycle %0d]: got %b want %b", i + 1, l_gnt, want[6 - i]);
      end
      l_addr = 14'(201 + i);
    end
    l_req = 0;
    checks++;
    if (pulses != MB) begin
      fails++;
      $display("FAIL max_burst_count: got %0d writes want %0d", pulses, MB);
    end
  endtask

  task automatic test_illegal;
    logic seen = 0;
    do_reset;
    l_req = 1; l_we = 1; l_sel = 2; l_addr = 14'h0400; l_wdata = 32'h1234_5678; l_last = 1;
    tick;
    tick;
    checks++;
    if ({row_we, val_we, col_we, err} !== 4'b0001) begin
      fails++;
      $display("FAIL illegal_row: got row_we=%b val_we=%b col_we=%b err=%b want 0 0 0 1", row_we, val_we, col_we, err);
    end
    l_we = 0; l_sel = 3;
    tick;
    tick;
    checks++;
    if (l_gnt !== 1'b1) begin
      fails++;
      $display("FAIL illegal_regrant: got l_gnt=%b want 1", l_gnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      l_req = 0;
      seen |= l_rvalid | m_rvalid | row_we;
    end
    checks++;
    if ({seen, err, busy} !== 3'b010) begin
      fails++;
      $display("FAIL illegal_read: got rvalid/we seen=%b err=%b busy=%b want 0 1 0", seen, err, busy);
    end
  endtask

  task automatic test_reset_inflight;
    logic seen = 0;
    do_reset;
    m_req = 1; m_we = 0; m_sel = 0; m_addr = 3; m_last = 1;
    tick;
    tick;
    reset = 1; m_req = 0;
    tick;
    checks++;
    if ({l_gnt, m_gnt, val_we, col_we, row_we, l_rvalid, m_rvalid, busy, err} !== 9'd0 ||
        {val_addr, col_addr, row_addr, val_din, col_din, row_din, l_rdata, m_rdata} !== '0) begin
      fails++;
      $display("FAIL reset_inflight: got ctl=%b val_addr=%h rdata=%h/%h want all 0",
               {l_gnt, m_gnt, val_we, col_we, row_we, l_rvalid, m_rvalid, busy, err}, val_addr, l_rdata, m_rdata);
    end
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      seen |= l_rvalid | m_rvalid;
    end
    checks++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_return: got rvalid seen=%b want 0", seen);
    end
  endtask

  task automatic test_random;
    logic xl, xm;
    logic [31:0] xd;
    do_reset;
    for (int c = 0; c < 3000; c++) begin
      reset = $urandom_range(0, 299) == 0;
      l_req = $urandom_range(0, 3) != 0;
      m_req = $urandom_range(0, 3) != 0;
      l_last = $urandom_range(0, 3) == 0;
      m_last = $urandom_range(0, 3) == 0;
      l_we = 1'($urandom_range(0, 1));
      m_we = 1'($urandom_range(0, 1));
      l_sel = $urandom_range(0, 15) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      m_sel = $urandom_range(0, 15) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      l_addr = $urandom_range(0, 7) == 0 ? 14'($urandom) : 14'($urandom_range(0, 31));
      m_addr = $urandom_range(0, 7) == 0 ? 14'($urandom) : 14'($urandom_range(0, 31));
      l_wdata = $urandom;
      m_wdata = $urandom;
      tick;
      xl = 0; xm = 0; xd = 0;
      foreach (rq[i]) if (rq[i].due == e) begin
        xl = !rq[i].m;
        xm = rq[i].m;
        xd = rq[i].d;
      end
      checks++;
      if ({l_gnt, m_gnt, val_we, col_we, row_we, l_rvalid, m_rvalid, err, busy} !==
          {st == 1, st == 2, xwe[0], xwe[1], xwe[2], xl, xm, merr, st != 0 || rq.size() != 0}) begin
        fails++;
        $display("FAIL rand_ctl[%0d]: got %b want %b", c,
                 {l_gnt, m_gnt, val_we, col_we, row_we, l_rvalid, m_rvalid, err, busy},
                 {st == 1, st == 2, xwe[0], xwe[1], xwe[2], xl, xm, merr, st != 0 || rq.size() != 0});
      end
      checks++;
      if ({val_addr, col_addr, row_addr} !== {xaddr[0], xaddr[1], xaddr[2][9:0]}) begin
        fails++;
        $display("FAIL rand_addr[%0d]: got %h %h %h want %h %h %h", c,
                 val_addr, col_addr, row_addr, xaddr[0], xaddr[1], xaddr[2][9:0]);
      end
      checks++;
      if ({l_rdata, m_rdata} !== {xl ? xd : 32'd0, xm ? xd : 32'd0}) begin
        fails++;
        $display("FAIL rand_rdata[%0d]: got %h %h want %h %h", c, l_rdata, m_rdata,
                 xl ? xd : 32'd0, xm ? xd : 32'd0);
      end
      if (xwe != 3'd0) begin
        checks++;
        if ({xwe[0] ? val_din : 32'd0, xwe[1] ? col_din : 32'd0, xwe[2] ? row_din : 32'd0} !==
            {xwe[0] ? xdin[0] : 32'd0, xwe[1] ? xdin[1] : 32'd0, xwe[2] ? xdin[2] : 32'd0}) begin
          fails++;
          $display("FAIL rand_din[%0d]: got %h %h %h want %h %h %h (we %b)", c,
                   val_din, col_din, row_din, xdin[0], xdin[1], xdin[2], xwe);
        end
      end
    end
    reset = 0;
  endtask

  initial begin
    test_reset;
    test_write_burst;
    test_contention;
    test_read;
    test_max_burst;
    test_illegal;
    test_reset_inflight;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/csr_port_arbiter.md
CSR_PORT_ARBITER -- requirements
Module: csr_port_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1: RAM read latency in cycles from registered RAM command to RAM dout valid (legal 1-4).
REQ-002 Parameter MAX_BURST, default 64: maximum accepted accesses per grant before forced release (legal 1-255).
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 l_req, m_req  in  1 each  loader / multiplier access request.
REQ-006 l_last, m_last  in  1 each  marks final access of the requester's burst.
REQ-007 l_we, m_we  in  1 each  write (1) / read (0).
REQ-008 l_sel, m_sel  in  2 each  target RAM: 0 value, 1 column, 2 row-pointer, 3 illegal.
REQ-009 l_addr, m_addr  in  14 each  word address.
REQ-010 l_wdata, m_wdata  in  32 each  write data.
REQ-011 l_gnt, m_gnt  out  1 each  grant, registered.
REQ-012 l_rvalid, m_rvalid / l_rdata, m_rdata  out  1 / 32 each  read return to the issuing requester.
REQ-013 val_addr, col_addr  out  14 each; row_addr  out  10; val_we, col_we, row_we  out  1 each; val_din, col_din, row_din  out  32 each  registered RAM port-A command.
REQ-014 val_dout, col_dout, row_dout  in  32 each  RAM port-A read data.
REQ-015 busy  out  1  state not IDLE or any read in flight.
REQ-016 err  out  1  sticky illegal-access flag.

Function
REQ-017 FSM states IDLE, GNT_L, GNT_M, TURN; l_gnt=1 only in GNT_L, m_gnt=1 only in GNT_M.
REQ-018 IDLE: only l_req -> GNT_L; only m_req -> GNT_M; both -> grant the requester not served last (rr pointer); neither -> stay IDLE.
REQ-019 Grant asserts the cycle after the request is sampled in IDLE; access is accepted in any cycle with req && gnt of the owner.
REQ-020 Owner req low while granted: no access that cycle; grant held; burst counter unchanged.
REQ-021 Release when an accepted access has last=1, or the accepted-access count reaches MAX_BURST; next state TURN, grant drops the following cycle.
REQ-022 TURN lasts exactly one cycle, then IDLE; rr pointer updated to the released requester on entering TURN.
REQ-023 Accepted legal access: the selected RAM's addr/we/din registered on the next edge; non-selected RAMs get we=0 and hold addr; one RAM command per cycle maximum.
REQ-024 Row RAM: row_addr = addr[9:0]; sel=2 with addr[13:10]!=0 is illegal.
REQ-025 Illegal access (sel=3 or bad row address): no RAM write, no read return, err set to 1 until reset; still counts toward the burst and honours last.
REQ-026 Accepted legal read: owner's rvalid pulses exactly 1+RD_LAT cycles after acceptance, with rdata taken from the dout of the addressed RAM; a tag pipeline (owner, sel) of depth 1+RD_LAT carries routing.
REQ-027 Returns are never dropped across grant changes; the non-addressed requester's rvalid stays 0 and its rdata is held at 0.
REQ-028 Writes produce no rvalid.
REQ-029 we fields are 0 whenever no access is accepted.

Reset
REQ-030 reset=1 at any edge: state IDLE, gnt 0, all we 0, all addr/din 0, rvalid 0, rdata 0, tag pipeline flushed, burst counter 0, err 0, busy 0, rr pointer favours loader.
REQ-031 Reset mid-burst or with reads in flight: in-flight reads are discarded and no rvalid is issued after reset.

Verification
REQ-032 Only l_req, 3 writes sel=0 addr 5,6,7 data A,B,C, last on 3rd -> l_gnt from cycle 1, val_we pulses with val_addr 5,6,7 at cycles 2-4, TURN, IDLE, busy low.
REQ-033 l_req and m_req both high from reset -> GNT_L first; after l_last -> TURN -> GNT_M; repeated contention alternates L,M,L.
REQ-034 m read sel=1 addr 0x0010, RD_LAT=1, col_dout=0xDEADBEEF -> m_rvalid=1, m_rdata=0xDEADBEEF 2 cycles after acceptance; l_rvalid stays 0.
REQ-035 MAX_BURST=4, l_req held high with last never set -> exactly 4 accesses, TURN, then regrant L if m_req low.
REQ-036 sel=2 addr 0x0400 write -> row_we stays 0, err=1 and stays 1; sel=3 read -> no rvalid.
REQ-037 reset asserted the cycle after a read acceptance -> no rvalid afterwards, all outputs at reset values next cycle.
